// File: rtl/up_pkg.sv
// up_pkg -- shared types and sizing for unidad_procesadora_param.
//   UP_W / UP_NREG / UP_AW : default data width, register count, register address width
//   ctrl_t                 : control word {reg_a, reg_b, dest, we, mb, alu_sel, sh_sel, mf, md}
//   alu_op_e, sh_op_e      : ALU and shifter operation codes
//   FLAG_*                 : bit positions inside the {V,C,N,Z} flags vector
//   mul_state_e            : multiplier sequencer states (used only when UP_MUL_EN is defined)
package up_pkg;

    localparam int UP_W    = 8;
    localparam int UP_NREG = 8;
    localparam int UP_AW   = $clog2(UP_NREG);

    typedef struct packed {
        logic [UP_AW-1:0] reg_a;
        logic [UP_AW-1:0] reg_b;
        logic [UP_AW-1:0] dest;
        logic             we;
        logic             mb;
        logic [3:0]       alu_sel;
        logic [1:0]       sh_sel;
        logic             mf;
        logic             md;
    } ctrl_t;

    typedef enum logic [3:0] {
        ALU_PASS  = 4'h0,
        ALU_INC   = 4'h1,
        ALU_ADD   = 4'h2,
        ALU_ADDC  = 4'h3,
        ALU_ADDNB = 4'h4,
        ALU_SUB   = 4'h5,
        ALU_DEC   = 4'h6,
        ALU_AND   = 4'h8,
        ALU_OR    = 4'hA,
        ALU_XOR   = 4'hC,
        ALU_NOT   = 4'hE,
        ALU_MUL   = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LSR  = 2'd1,
        SH_LSL  = 2'd2,
        SH_ASR  = 2'd3
    } sh_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/banco_registros.sv
// banco_registros -- NREG x W register file, synchronous reset to zero.
//   clk, rst_n        : clock, synchronous active-low reset
//   we, waddr, wdata  : single synchronous write port
//   raddr_a, rdata_a  : asynchronous read port A
//   raddr_b, rdata_b  : asynchronous read port B
// A read of the register being written returns the old value until the edge.
module banco_registros #(
    parameter int W    = 8,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/unidad_procesadora_param.sv
// unidad_procesadora_param -- register file + ALU + shifter + B/F/D muxes under one control word.
//   clk, rst_n     : clock, synchronous active-low reset
//   ctrl_valid     : control word valid; accepted when not busy
//   control        : ctrl_t control word
//   datain         : external data, selected onto D when md=1
//   constant_in    : constant operand, B bus when mb=0
//   flags          : registered {V,C,N,Z}
//   dataout        : B bus (combinational)
//   adr_out        : A bus (combinational)
//   busy           : multi-cycle multiply in progress
//   done           : one-cycle pulse after an operation commits
// Build option: define UP_MUL_EN to turn alu_sel=F into a W-cycle shift-add multiply;
// without it alu_sel=F passes A and busy is tied low.
//
// Multiplier sequencer (UP_MUL_EN only):
//   state   | meaning
//   ST_IDLE | accepting control words
//   ST_MUL  | shift-add in progress; last step writes result and flags
module unidad_procesadora_param
    import up_pkg::*;
#(
    parameter int W    = UP_W,
    parameter int NREG = UP_NREG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ctrl_valid,
    input  ctrl_t        control,
    input  logic [W-1:0] datain,
    input  logic [W-1:0] constant_in,
    output logic [3:0]   flags,
    output logic [W-1:0] dataout,
    output logic [W-1:0] adr_out,
    output logic         busy,
    output logic         done
);

    localparam int AW = $clog2(NREG);

    logic [W-1:0] a_bus, reg_b_val, b_bus, add_b, logic_y, alu_y, sh_y, f_bus, d_bus;
    logic [W:0]   sum;
    logic         add_cin, is_arith, alu_c, alu_v;
    logic [3:0]   alu_flags, mul_flags;
    logic         accept, mul_start, single_acc, mul_last, mul_we;
    logic         rf_we;
    logic [AW-1:0] rf_waddr, mul_dest;
    logic [W-1:0] rf_wdata, mul_res;

    banco_registros #(.W(W), .NREG(NREG), .AW(AW)) u_banco (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (control.reg_a),
        .raddr_b (control.reg_b),
        .rdata_a (a_bus),
        .rdata_b (reg_b_val)
    );

    assign b_bus   = control.mb ? reg_b_val : constant_in;
    assign adr_out = a_bus;
    assign dataout = b_bus;

    // Every arithmetic op is A + add_b + add_cin, so one adder yields C and V uniformly;
    // subtract-style ops therefore report carry = not-borrow.
    always_comb begin
        add_b    = '0;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (control.alu_sel)
            ALU_INC:   add_cin = 1'b1;
            ALU_ADD:   add_b = b_bus;
            ALU_ADDC:  begin add_b = b_bus;  add_cin = 1'b1; end
            ALU_ADDNB: add_b = ~b_bus;
            ALU_SUB:   begin add_b = ~b_bus; add_cin = 1'b1; end
            ALU_DEC:   add_b = '1;
            default:   is_arith = 1'b0;
        endcase
        sum = {1'b0, a_bus} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

        case (control.alu_sel)
            ALU_AND: logic_y = a_bus & b_bus;
            ALU_OR:  logic_y = a_bus | b_bus;
            ALU_XOR: logic_y = a_bus ^ b_bus;
            ALU_NOT: logic_y = ~a_bus;
            default: logic_y = a_bus;
        endcase

        alu_y = is_arith ? sum[W-1:0] : logic_y;
        alu_c = is_arith & sum[W];
        alu_v = is_arith & (a_bus[W-1] == add_b[W-1]) & (sum[W-1] != a_bus[W-1]);
    end

    always_comb begin
        case (control.sh_sel)
            SH_LSR:  sh_y = {1'b0, b_bus[W-1:1]};
            SH_LSL:  sh_y = {b_bus[W-2:0], 1'b0};
            SH_ASR:  sh_y = {b_bus[W-1], b_bus[W-1:1]};
            default: sh_y = b_bus;
        endcase
    end

    assign f_bus = control.mf ? sh_y : alu_y;
    assign d_bus = control.md ? datain : f_bus;

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_V] = alu_v;
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_N] = d_bus[W-1];
        alu_flags[FLAG_Z] = (d_bus == '0);
    end

    assign accept     = ctrl_valid & ~busy;
    assign single_acc = accept & ~mul_start;

`ifdef UP_MUL_EN
    localparam int CNTW = $clog2(W + 1);

    mul_state_e      state, state_nx;
    logic [CNTW-1:0] cnt;
    logic [2*W-1:0]  acc, mcand, acc_nx;
    logic [W-1:0]    mplier;

    assign mul_start = accept & (control.alu_sel == ALU_MUL) & ~control.mf & ~control.md;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (mul_start) state_nx = ST_MUL;
            ST_MUL:  if (cnt == CNTW'(1)) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_MUL);
        mul_last = (state == ST_MUL) && (cnt == CNTW'(1));
    end

    // acc_nx includes the current step, so on the last step it already holds A*B.
    assign acc_nx = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            mul_dest <= '0;
            mul_we   <= 1'b0;
        end else if (mul_start) begin
            cnt      <= CNTW'(W);
            acc      <= '0;
            mcand    <= {{W{1'b0}}, a_bus};
            mplier   <= b_bus;
            mul_dest <= control.dest;
            mul_we   <= control.we;
        end else if (busy) begin
            cnt    <= cnt - CNTW'(1);
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign mul_res = acc_nx[W-1:0];

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_C] = |acc_nx[2*W-1:W];
        mul_flags[FLAG_N] = acc_nx[W-1];
        mul_flags[FLAG_Z] = (acc_nx[W-1:0] == '0);
    end
`else
    assign mul_start = 1'b0;
    assign busy      = 1'b0;
    assign mul_last  = 1'b0;
    assign mul_we    = 1'b0;
    assign mul_dest  = '0;
    assign mul_res   = '0;
    assign mul_flags = '0;
`endif

    assign rf_we    = (single_acc & control.we) | (mul_last & mul_we);
    assign rf_waddr = mul_last ? mul_dest : control.dest;
    assign rf_wdata = mul_last ? mul_res : d_bus;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= '0;
            done  <= 1'b0;
        end else begin
            done <= single_acc | mul_last;
            if (single_acc & ~control.mf & ~control.md) flags <= alu_flags;
            else if (mul_last)                          flags <= mul_flags;
        end
    end

endmodule

// File: tb/tb_unidad_procesadora_param.sv
// Scoreboard bench for unidad_procesadora_param (W=8, NREG=8).
// Expected flags are queued when an operation is issued and compared when done pulses.
module tb_unidad_procesadora_param;
    import up_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ctrl_valid;
    ctrl_t      control;
    logic [7:0] datain, constant_in, dataout, adr_out;
    logic [3:0] flags;
    logic       busy, done;

    int n_chk = 0;
    int n_err = 0;
    int cycles;
    logic [3:0] fl;
    logic [3:0] exp_q[$];
    string      tag_q[$];
    logic [3:0] e_fl;
    string      e_tag;

    unidad_procesadora_param #(.W(8), .NREG(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_valid  (ctrl_valid),
        .control     (control),
        .datain      (datain),
        .constant_in (constant_in),
        .flags       (flags),
        .dataout     (dataout),
        .adr_out     (adr_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t mk(input int ra, input int rb, input int d, input logic we,
                                 input logic mb, input logic [3:0] alu, input logic [1:0] sh,
                                 input logic mf, input logic md);
        ctrl_t c;
        c.reg_a   = UP_AW'(ra);
        c.reg_b   = UP_AW'(rb);
        c.dest    = UP_AW'(d);
        c.we      = we;
        c.mb      = mb;
        c.alu_sel = alu;
        c.sh_sel  = sh;
        c.mf      = mf;
        c.md      = md;
        return c;
    endfunction

    task automatic op(input ctrl_t c, input logic [7:0] din, input logic [7:0] cst,
                      input logic [3:0] exp_flags, input string tag);
        @(negedge clk);
        control     = c;
        datain      = din;
        constant_in = cst;
        ctrl_valid  = 1'b1;
        exp_q.push_back(exp_flags);
        tag_q.push_back(tag);
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic load(input int d, input logic [7:0] v);
        op(mk(0, 0, d, 1'b1, 1'b0, ALU_PASS, SH_NONE, 1'b0, 1'b1), v, 8'h00, fl, "load_flags");
    endtask

    task automatic rd(input int idx, input logic [7:0] exp, input string tag);
        @(negedge clk);
        ctrl_valid = 1'b0;
        control    = mk(idx, idx, 0, 1'b0, 1'b1, ALU_PASS, SH_NONE, 1'b0, 1'b0);
        #1;
        chk({tag, "_b"}, dataout, exp);
        chk({tag, "_a"}, adr_out, exp);
    endtask

    // Output side of the scoreboard: every done pulse must match a queued operation.
    always begin
        @(posedge clk);
        #1;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                e_fl  = exp_q.pop_front();
                e_tag = tag_q.pop_front();
                chk(e_tag, flags, e_fl);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ctrl_valid  = 1'b0;
        control     = '0;
        datain      = 8'h00;
        constant_in = 8'h00;
        fl          = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", flags, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd(i, 8'h00, "rst_reg");

        load(3, 8'hA5);
        rd(3, 8'hA5, "load_r3");

        load(1, 8'h05);
        load(2, 8'h07);
        op(mk(1, 2, 0, 1'b1, 1'b1, ALU_SUB, SH_NONE, 1'b0, 1'b0), 8'h00, 8'h00, 4'b0010, "sub_flags");
        fl = 4'b0010;
        rd(0, 8'hFE, "sub_r0");

        load(1, 8'h7F);
        op(mk(1, 0, 4, 1'b1, 1'b0, ALU_ADD, SH_NONE, 1'b0, 1'b0), 8'h00, 8'h01, 4'b1010, "add_ovf_flags");
        fl = 4'b1010;
        rd(4, 8'h80, "add_r4");

        @(negedge clk);
        control    = mk(0, 0, 4, 1'b1, 1'b0, ALU_PASS, SH_NONE, 1'b0, 1'b1);
        datain     = 8'hFF;
        ctrl_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("novalid_done", done, 1'b0);
        rd(4, 8'h80, "novalid_r4");

        load(5, 8'hFF);
        op(mk(5, 0, 6, 1'b1, 1'b1, ALU_INC, SH_NONE, 1'b0, 1'b0), 8'h00, 8'h00, 4'b0101, "inc_wrap_flags");
        fl = 4'b0101;
        rd(6, 8'h00, "inc_r6");

        op(mk(1, 0, 3, 1'b0, 1'b0, ALU_AND, SH_NONE, 1'b0, 1'b0), 8'h00, 8'h80, 4'b0001, "and_nowe_flags");
        fl = 4'b0001;
        rd(3, 8'hA5, "and_nowe_r3");

        load(5, 8'h81);
        op(mk(0, 5, 7, 1'b1, 1'b1, ALU_PASS, SH_LSL, 1'b1, 1'b0), 8'h00, 8'h00, fl, "lsl_flags");
        rd(7, 8'h02, "lsl_r7");
        op(mk(0, 0, 7, 1'b1, 1'b0, ALU_PASS, SH_ASR, 1'b1, 1'b0), 8'h00, 8'h80, fl, "asr_flags");
        rd(7, 8'hC0, "asr_r7");
        op(mk(0, 0, 2, 1'b1, 1'b0, ALU_PASS, SH_LSR, 1'b1, 1'b0), 8'h00, 8'h81, fl, "lsr_flags");
        rd(2, 8'h40, "lsr_r2");

        load(1, 8'h0C);
        load(2, 8'h0B);
`ifdef UP_MUL_EN
        @(negedge clk);
        control    = mk(1, 2, 0, 1'b1, 1'b1, ALU_MUL, SH_NONE, 1'b0, 1'b0);
        ctrl_valid = 1'b1;
        exp_q.push_back(4'b0010);
        tag_q.push_back("mul_flags");
        @(posedge clk);
        #1;
        ctrl_valid = 1'b0;
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            if (cycles == 3) begin
                control    = mk(0, 0, 0, 1'b1, 1'b0, ALU_PASS, SH_NONE, 1'b0, 1'b1);
                datain     = 8'hFF;
                ctrl_valid = 1'b1;
            end else begin
                ctrl_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        ctrl_valid = 1'b0;
        chk("mul_busy_cycles", cycles, 8);
        fl = 4'b0010;
        rd(0, 8'h84, "mul_r0");

        load(1, 8'h03);
        load(2, 8'h03);
        @(negedge clk);
        control    = mk(1, 2, 0, 1'b1, 1'b1, ALU_MUL, SH_NONE, 1'b0, 1'b0);
        ctrl_valid = 1'b1;
        @(posedge clk);
        #1;
        ctrl_valid = 1'b0;
        chk("abort_busy_high", busy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy_low", busy, 1'b0);
        chk("abort_flags", flags, 4'h0);
        repeat (12) @(posedge clk);
        fl = 4'b0000;
        rd(0, 8'h00, "abort_r0");
`else
        @(negedge clk);
        control    = mk(1, 2, 0, 1'b1, 1'b1, ALU_MUL, SH_NONE, 1'b0, 1'b0);
        ctrl_valid = 1'b1;
        exp_q.push_back(4'b0000);
        tag_q.push_back("mulpass_flags");
        @(posedge clk);
        #1;
        chk("mulpass_busy", busy, 1'b0);
        @(negedge clk);
        ctrl_valid = 1'b0;
        fl = 4'b0000;
        rd(0, 8'h0C, "mulpass_r0");
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
